// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory-stage access sequencer: FSM states, pointer
// select codes, addressing modes and access widths.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBeat0 = 2'b01,
    StBeat1 = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Same encoding as the existing SP/X/Y/Z address select mux.
  typedef enum logic [1:0] {
    PtrSp = 2'b00,
    PtrX  = 2'b01,
    PtrY  = 2'b10,
    PtrZ  = 2'b11
  } ptr_sel_e;

  typedef enum logic [1:0] {
    ModeDisp    = 2'b00,
    ModePostInc = 2'b01,
    ModePreDec  = 2'b10,
    ModePostDec = 2'b11
  } mode_e;

  localparam int unsigned BeatsNarrow = 1;
  localparam int unsigned BeatsWide   = 2;

  function automatic int unsigned beat_count(input logic wide);
    return wide ? BeatsWide : BeatsNarrow;
  endfunction

endpackage

// File: rtl/mem_ptr_access_ctrl_if.sv
// Request/response, data-memory and pointer-writeback signals of the access
// sequencer. The controller takes the slave side.
interface mem_ptr_access_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DISP_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic              req_write;
  logic [1:0]        req_mode;
  logic [DISP_W-1:0] req_disp;
  logic              req_wide;
  logic [15:0]       req_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;

  logic              ptr_wb_en;
  logic [1:0]        ptr_wb_sel;
  logic [ADDR_W-1:0] ptr_wb_value;

  modport slave (
    input  req_valid, req_sel, req_write, req_mode, req_disp, req_wide, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err, ptr_wb_en, ptr_wb_sel, ptr_wb_value
  );

  modport master (
    output req_valid, req_sel, req_write, req_mode, req_disp, req_wide, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err, ptr_wb_en, ptr_wb_sel, ptr_wb_value
  );
endinterface

// File: rtl/mem_ptr_arith.sv
// Effective address and pointer writeback value for one access, from the
// latched base pointer, addressing mode, displacement and access width.
module mem_ptr_arith
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DISP_W = 6
) (
  input  logic [ADDR_W-1:0] base,
  input  mode_e             mode,
  input  logic [DISP_W-1:0] disp,
  input  logic              wide,
  output logic [ADDR_W-1:0] eff_addr,
  output logic [ADDR_W-1:0] wb_value
);

  logic [ADDR_W-1:0] n;
  assign n = ADDR_W'(beat_count(wide));

  always_comb begin
    eff_addr = base;
    wb_value = base;
    unique case (mode)
      ModeDisp:    eff_addr = base + ADDR_W'(disp);
      ModePostInc: wb_value = base + n;
      ModePreDec: begin
        eff_addr = base - n;
        wb_value = base - n;
      end
      ModePostDec: wb_value = base - n;
      default:     ;
    endcase
  end

endmodule

// File: rtl/mem_ptr_access_ctrl.sv
// Memory-stage access sequencer: latches one load/store, runs 1 or 2 byte beats
// on the data-memory bus, then returns data and a pointer writeback pulse.
module mem_ptr_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DISP_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_ptr_access_ctrl_if.slave bus,
  input  logic [ADDR_W-1:0]   x_ptr,
  input  logic [ADDR_W-1:0]   y_ptr,
  input  logic [ADDR_W-1:0]   z_ptr,
  input  logic [ADDR_W-1:0]   stack_ptr,
  output logic                stall
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        sel_q;
  logic              write_q;
  mode_e             mode_q;
  logic [DISP_W-1:0] disp_q;
  logic              wide_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] wb_value;
  logic              accept, in_beat, beat1, done;

  assign accept  = (state_q == StIdle) && bus.req_valid;
  assign in_beat = (state_q == StBeat0) || (state_q == StBeat1);
  assign beat1   = (state_q == StBeat1);
  assign done    = (state_q == StDone);

  always_comb begin
    sel_base = stack_ptr;
    unique case (ptr_sel_e'(bus.req_sel))
      PtrSp:   sel_base = stack_ptr;
      PtrX:    sel_base = x_ptr;
      PtrY:    sel_base = y_ptr;
      PtrZ:    sel_base = z_ptr;
      default: sel_base = stack_ptr;
    endcase
  end

  mem_ptr_arith #(
    .ADDR_W (ADDR_W),
    .DISP_W (DISP_W)
  ) u_arith (
    .base     (base_q),
    .mode     (mode_q),
    .disp     (disp_q),
    .wide     (wide_q),
    .eff_addr (eff_addr),
    .wb_value (wb_value)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StBeat0;
          tmo_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      StBeat0, StBeat1: begin
        if (bus.mem_ready) begin
          if (!write_q) begin
            if (beat1) rdata_d[15:8] = bus.mem_rdata;
            else       rdata_d[7:0]  = bus.mem_rdata;
          end
          tmo_d   = '0;
          state_d = (!beat1 && wide_q) ? StBeat1 : StDone;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      write_q <= 1'b0;
      mode_q  <= ModeDisp;
      disp_q  <= '0;
      wide_q  <= 1'b0;
      wdata_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        sel_q   <= bus.req_sel;
        write_q <= bus.req_write;
        mode_q  <= mode_e'(bus.req_mode);
        disp_q  <= bus.req_disp;
        wide_q  <= bus.req_wide;
        wdata_q <= bus.req_wdata;
        base_q  <= sel_base;
      end
    end
  end

  // Outputs are gated to zero outside their active states so idle/reset values are clean.
  always_comb begin
    bus.req_ready    = (state_q == StIdle);
    stall            = (state_q != StIdle);
    bus.mem_addr     = in_beat ? (eff_addr + ADDR_W'(beat1)) : '0;
    bus.mem_re       = in_beat && !write_q;
    bus.mem_we       = in_beat && write_q;
    bus.mem_wdata    = !in_beat ? 8'h00 : (beat1 ? wdata_q[15:8] : wdata_q[7:0]);
    bus.rsp_valid    = done;
    bus.rsp_err      = done && err_q;
    bus.rsp_rdata    = (done && !err_q) ? rdata_q : 16'h0000;
    bus.ptr_wb_en    = done && !err_q && (mode_q != ModeDisp);
    bus.ptr_wb_sel   = bus.ptr_wb_en ? sel_q : 2'b00;
    bus.ptr_wb_value = bus.ptr_wb_en ? wb_value : '0;
  end

endmodule

// File: tb/tb_mem_ptr_access_ctrl.sv
// Scoreboard bench for mem_ptr_access_ctrl: stimulus pushes expected beats and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_ptr_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          hold;
  } beat_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        wb_en;
    logic [1:0]  wb_sel;
    logic [15:0] wb_value;
    int          lat;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] x_ptr = '0, y_ptr = '0, z_ptr = '0, stack_ptr = '0;
  logic        stall;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rsp_cnt = 0;
  int          hold_cnt = 0;
  int          ready_delay = 0;
  logic        never_ready = 1'b0;
  int          wait_cnt = 0;
  beat_t       beat_q[$];
  rsp_t        rsp_q[$];

  mem_ptr_access_ctrl_if #(.ADDR_W(16), .DISP_W(6)) bus ();

  mem_ptr_access_ctrl #(
    .ADDR_W      (16),
    .DISP_W      (6),
    .TIMEOUT_CYC (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .x_ptr     (x_ptr),
    .y_ptr     (y_ptr),
    .z_ptr     (z_ptr),
    .stack_ptr (stack_ptr),
    .stall     (stall)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    case (a)
      16'h1000: return 8'hAB;
      16'h0040: return 8'h5C;
      16'h3000: return 8'h34;
      16'h3001: return 8'h12;
      default:  return 8'h00;
    endcase
  endfunction

  assign bus.mem_rdata = mem_fn(bus.mem_addr);
  assign bus.mem_ready = !never_ready && (wait_cnt >= ready_delay);

  always @(posedge clock) begin
    if ((bus.mem_re || bus.mem_we) && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  initial forever begin
    beat_t b;
    rsp_t  r;
    int    hold;
    @(negedge clock);
    if (reset_n) begin
      chk("bus_invariants",
          {31'd0, !(bus.mem_re && bus.mem_we) && (stall == !bus.req_ready) &&
                  (!(bus.mem_re || bus.mem_we) || (stall && !bus.rsp_valid))}, 32'd1);
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.mem_re || bus.mem_we) begin
        hold = hold_cnt + 1;
        if (bus.mem_ready) begin
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %0h expected none", bus.mem_addr);
          end else begin
            b = beat_q.pop_front();
            chk("beat_addr", {16'd0, bus.mem_addr}, {16'd0, b.addr});
            chk("beat_we", {31'd0, bus.mem_we}, {31'd0, b.we});
            if (b.we) chk("beat_wdata", {24'd0, bus.mem_wdata}, {24'd0, b.wdata});
            chk("beat_hold", hold, b.hold);
          end
          hold_cnt = 0;
        end else begin
          hold_cnt = hold;
          if (beat_q.size() > 0)
            chk("beat_addr_held", {16'd0, bus.mem_addr}, {16'd0, beat_q[0].addr});
        end
      end else begin
        hold_cnt = 0;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rdata %0h expected none", bus.rsp_rdata);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, r.rdata});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, r.err});
          chk("wb_en", {31'd0, bus.ptr_wb_en}, {31'd0, r.wb_en});
          if (r.wb_en) begin
            chk("wb_sel", {30'd0, bus.ptr_wb_sel}, {30'd0, r.wb_sel});
            chk("wb_value", {16'd0, bus.ptr_wb_value}, {16'd0, r.wb_value});
          end
          chk("rsp_latency", cyc - acc_cyc, r.lat);
        end
      end
    end
  end

  task automatic push_beat(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input int hold);
    beat_t b;
    b.addr = a; b.we = we; b.wdata = d; b.hold = hold;
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [15:0] rd, input logic err, input logic wb_en,
                          input logic [1:0] wb_sel, input logic [15:0] wb_val, input int lat);
    rsp_t r;
    r.rdata = rd; r.err = err; r.wb_en = wb_en; r.wb_sel = wb_sel;
    r.wb_value = wb_val; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic [1:0] sel, input logic wr, input logic [1:0] mode,
                       input logic [5:0] disp, input logic wide, input logic [15:0] wdata,
                       input logic keep_valid);
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_write = wr;
    bus.req_mode  = mode;
    bus.req_disp  = disp;
    bus.req_wide  = wide;
    bus.req_wdata = wdata;
    @(posedge clock); #1;
    if (keep_valid) begin
      bus.req_sel   = 2'b11;
      bus.req_write = ~wr;
      bus.req_mode  = 2'b10;
      bus.req_wdata = 16'hFFFF;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string name);
    int  start;
    bit  seen;
    start = rsp_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (rsp_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no rsp_valid expected one within 40 cycles", name);
    end
  endtask

  initial begin
    bit found;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.req_write = 1'b0;
    bus.req_mode  = '0;
    bus.req_disp  = '0;
    bus.req_wide  = 1'b0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_outputs", {26'd0, stall, bus.mem_re, bus.mem_we, bus.rsp_valid, bus.rsp_err,
                        bus.ptr_wb_en}, 32'd0);
    chk("rst_buses", {bus.mem_addr, bus.rsp_rdata}, 32'd0);
    #1 reset_n = 1'b1;

    // Narrow post-inc load from X.
    x_ptr = 16'h1000;
    push_beat(16'h1000, 1'b0, 8'h00, 1);
    push_rsp(16'h00AB, 1'b0, 1'b1, 2'b01, 16'h1001, 2);
    issue(2'b01, 1'b0, 2'b01, 6'd0, 1'b0, 16'h0000, 1'b0);
    wait_rsp("narrow_load");

    // Wide displacement store via Y, no writeback.
    y_ptr = 16'h2000;
    push_beat(16'h2005, 1'b1, 8'hEF, 1);
    push_beat(16'h2006, 1'b1, 8'hBE, 1);
    push_rsp(16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 3);
    issue(2'b10, 1'b1, 2'b00, 6'd5, 1'b1, 16'hBEEF, 1'b0);
    wait_rsp("wide_store");

    // Wide push: pre-dec SP from 0 wraps.
    stack_ptr = 16'h0000;
    push_beat(16'hFFFE, 1'b1, 8'h34, 1);
    push_beat(16'hFFFF, 1'b1, 8'h12, 1);
    push_rsp(16'h0000, 1'b0, 1'b1, 2'b00, 16'hFFFE, 3);
    issue(2'b00, 1'b1, 2'b10, 6'd0, 1'b1, 16'h1234, 1'b0);
    wait_rsp("push");

    // Post-dec load from Z with 3 wait states (ready on the last timeout cycle).
    z_ptr = 16'h0040;
    ready_delay = 3;
    push_beat(16'h0040, 1'b0, 8'h00, 4);
    push_rsp(16'h005C, 1'b0, 1'b1, 2'b11, 16'h003F, 5);
    issue(2'b11, 1'b0, 2'b11, 6'd0, 1'b0, 16'h0000, 1'b0);
    wait_rsp("wait_load");
    ready_delay = 0;

    // Wide load, pointer input changes and req_valid held high while busy.
    x_ptr = 16'h3000;
    push_beat(16'h3000, 1'b0, 8'h00, 1);
    push_beat(16'h3001, 1'b0, 8'h00, 1);
    push_rsp(16'h1234, 1'b0, 1'b1, 2'b01, 16'h3002, 3);
    issue(2'b01, 1'b0, 2'b01, 6'd0, 1'b1, 16'h0000, 1'b1);
    x_ptr = 16'hDEAD;
    wait_rsp("wide_load");

    // Timeout: mem_ready never asserted.
    never_ready = 1'b1;
    y_ptr = 16'h0100;
    push_rsp(16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 5);
    issue(2'b10, 1'b0, 2'b01, 6'd0, 1'b0, 16'h0000, 1'b0);
    wait_rsp("timeout");
    never_ready = 1'b0;

    // Reset during BEAT1 of a wide load: no response, no writeback.
    x_ptr = 16'h3000;
    push_beat(16'h3000, 1'b0, 8'h00, 1);
    push_beat(16'h3001, 1'b0, 8'h00, 1);
    issue(2'b01, 1'b0, 2'b01, 6'd0, 1'b1, 16'h0000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.mem_re && bus.mem_addr == 16'h3001) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_beat1", {31'd0, found}, 32'd1);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_quiet", {28'd0, bus.mem_re, bus.mem_we, bus.rsp_valid, bus.ptr_wb_en}, 32'd0);
    repeat (6) @(posedge clock);

    @(negedge clock);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
